// File: rtl/counter_updown_rpt_pkg.sv
// Shared types and helpers for the bounded up/down counter with key auto-repeat.
package counter_updown_rpt_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RPT  = 2'd2
  } rpt_state_e;

  typedef enum logic {
    DIR_UP = 1'b0,
    DIR_DN = 1'b1
  } dir_e;

  localparam int KEY_UP = 0;
  localparam int KEY_DN = 1;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/counter_updown_rpt_key_repeat_fsm.sv
// Key press/hold/auto-repeat sequencer: turns held key levels into single-cycle step requests.
module counter_updown_rpt_key_repeat_fsm
  import counter_updown_rpt_pkg::*;
#(
  parameter int REP_DLY = 4,
  parameter int REP_PER = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       pause,
  input  logic [1:0] key,
  input  logic       load,
  output logic       step_up,
  output logic       step_dn
);

  localparam int TMR_W = $clog2(max_int(REP_DLY, REP_PER) + 1);

  rpt_state_e       state_q, state_d;
  dir_e             dir_q, dir_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic [TMR_W:0]   timer_inc;
  logic             single, step;
  dir_e             key_dir, step_dir;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      dir_q   <= DIR_UP;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q   <= dir_d;
      timer_q <= timer_d;
    end
  end

  // Hold state waits REP_DLY held ticks and repeats on the next one; repeat state steps every REP_PER ticks.
  always_comb begin
    state_d   = state_q;
    dir_d     = dir_q;
    timer_d   = timer_q;
    step      = 1'b0;
    step_dir  = dir_q;
    single    = key[KEY_UP] ^ key[KEY_DN];
    key_dir   = key[KEY_DN] ? DIR_DN : DIR_UP;
    timer_inc = {1'b0, timer_q} + 1'b1;
    if (load) begin
      state_d = ST_IDLE;
      timer_d = '0;
    end else if (en && !pause) begin
      if (!single) begin
        state_d = ST_IDLE;
        timer_d = '0;
      end else if (state_q == ST_IDLE || key_dir != dir_q) begin
        step     = 1'b1;
        step_dir = key_dir;
        dir_d    = key_dir;
        state_d  = ST_HOLD;
        timer_d  = '0;
      end else begin
        case (state_q)
          ST_HOLD: begin
            if (REP_DLY != 0) begin
              if (timer_q == TMR_W'(REP_DLY)) begin
                step    = 1'b1;
                timer_d = '0;
                state_d = ST_RPT;
              end else begin
                timer_d = timer_inc[TMR_W-1:0];
              end
            end
          end
          ST_RPT: begin
            if (timer_inc >= (TMR_W+1)'(REP_PER)) begin
              step    = 1'b1;
              timer_d = '0;
            end else begin
              timer_d = timer_inc[TMR_W-1:0];
            end
          end
          default: begin
            state_d = ST_IDLE;
            timer_d = '0;
          end
        endcase
      end
    end
  end

  assign step_up = step && (step_dir == DIR_UP);
  assign step_dn = step && (step_dir == DIR_DN);

endmodule

// File: rtl/counter_updown_rpt.sv
// Bounded up/down counter in [MIN_VAL, MAX_VAL] with wrap/saturate, sync load and carry/borrow strobes.
module counter_updown_rpt
  import counter_updown_rpt_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int MIN_VAL   = 2,
  parameter int MAX_VAL   = 11,
  parameter int RESET_VAL = 2,
  parameter int STEP      = 1,
  parameter int REP_DLY   = 4,
  parameter int REP_PER   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             pause,
  input  logic [1:0]       key,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             mode,
  output logic [WIDTH-1:0] d_out,
  output logic             c_out,
  output logic             b_out,
  output logic             at_max,
  output logic             at_min
);

  if (!(MIN_VAL < MAX_VAL && longint'(MAX_VAL) < (longint'(1) << WIDTH))) begin : g_bad_range
    $error("counter_updown_rpt: need MIN_VAL < MAX_VAL < 2**WIDTH");
  end
  if (!(MIN_VAL <= RESET_VAL && RESET_VAL <= MAX_VAL)) begin : g_bad_reset
    $error("counter_updown_rpt: RESET_VAL outside [MIN_VAL, MAX_VAL]");
  end
  if (!(STEP >= 1 && STEP <= MAX_VAL - MIN_VAL)) begin : g_bad_step
    $error("counter_updown_rpt: STEP must be in [1, MAX_VAL-MIN_VAL]");
  end
  if (REP_PER < 1) begin : g_bad_per
    $error("counter_updown_rpt: REP_PER must be >= 1");
  end

  localparam logic [WIDTH-1:0] MIN_W  = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_W  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_W  = WIDTH'(RESET_VAL);
  localparam logic [WIDTH:0]   MIN_X  = (WIDTH+1)'(MIN_VAL);
  localparam logic [WIDTH:0]   MAX_X  = (WIDTH+1)'(MAX_VAL);
  localparam logic [WIDTH:0]   STEP_X = (WIDTH+1)'(STEP);

  logic             step_up, step_dn;
  logic [WIDTH-1:0] d_nxt;
  logic             c_nxt, b_nxt;

  function automatic logic [WIDTH-1:0] clamp_val(input logic [WIDTH-1:0] v);
    if (v < MIN_W)      return MIN_W;
    else if (v > MAX_W) return MAX_W;
    else                return v;
  endfunction

  // Limit check in WIDTH+1 bits so d+STEP cannot overflow silently; returns {strobe, next count}.
  function automatic logic [WIDTH:0] limit_up(input logic [WIDTH-1:0] d, input logic sat);
    logic [WIDTH:0] sum;
    sum = {1'b0, d} + STEP_X;
    if (sum > MAX_X) return sat ? {1'b0, MAX_W} : {1'b1, MIN_W};
    else             return {1'b0, sum[WIDTH-1:0]};
  endfunction

  function automatic logic [WIDTH:0] limit_dn(input logic [WIDTH-1:0] d, input logic sat);
    logic [WIDTH:0] diff;
    diff = {1'b0, d} - STEP_X;
    if ({1'b0, d} < MIN_X + STEP_X) return sat ? {1'b0, MIN_W} : {1'b1, MAX_W};
    else                            return {1'b0, diff[WIDTH-1:0]};
  endfunction

  counter_updown_rpt_key_repeat_fsm #(
    .REP_DLY (REP_DLY),
    .REP_PER (REP_PER)
  ) u_fsm (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .pause   (pause),
    .key     (key),
    .load    (load),
    .step_up (step_up),
    .step_dn (step_dn)
  );

  always_comb begin
    d_nxt = d_out;
    c_nxt = 1'b0;
    b_nxt = 1'b0;
    if (load) begin
      d_nxt = clamp_val(load_val);
    end else if (step_up) begin
      {c_nxt, d_nxt} = limit_up(d_out, mode);
    end else if (step_dn) begin
      {b_nxt, d_nxt} = limit_dn(d_out, mode);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      d_out <= RST_W;
      c_out <= 1'b0;
      b_out <= 1'b0;
    end else begin
      d_out <= d_nxt;
      c_out <= c_nxt;
      b_out <= b_nxt;
    end
  end

  assign at_max = (d_out == MAX_W);
  assign at_min = (d_out == MIN_W);

endmodule

// File: tb/tb_counter_updown_rpt.sv
// Bench for counter_updown_rpt: default instance plus a STEP=3, [0,9] instance sharing the same stimulus.
module tb_counter_updown_rpt;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       en, pause, load, mode;
  logic [1:0] key;
  logic [7:0] load_val;
  logic [7:0] d0, d1;
  logic       c0, c1, b0, b1, mx0, mx1, mn0, mn1;

  int n_cmp = 0;
  int n_bad = 0;

  localparam int REP_DLY = 4;
  localparam int REP_PER = 2;
  int mn_v[2]  = '{2, 0};
  int mx_v[2]  = '{11, 9};
  int st_v[2]  = '{1, 3};
  int rst_v[2] = '{2, 0};

  always #5 clk = ~clk;

  counter_updown_rpt u0 (
    .clk(clk), .rst(rst), .en(en), .pause(pause), .key(key), .load(load),
    .load_val(load_val), .mode(mode), .d_out(d0), .c_out(c0), .b_out(b0),
    .at_max(mx0), .at_min(mn0)
  );

  counter_updown_rpt #(
    .WIDTH(8), .MIN_VAL(0), .MAX_VAL(9), .RESET_VAL(0), .STEP(3),
    .REP_DLY(REP_DLY), .REP_PER(REP_PER)
  ) u1 (
    .clk(clk), .rst(rst), .en(en), .pause(pause), .key(key), .load(load),
    .load_val(load_val), .mode(mode), .d_out(d1), .c_out(c1), .b_out(b1),
    .at_max(mx1), .at_min(mn1)
  );

  // Model: a press steps at once; a held key steps again after REP_DLY+1 ticks, then every REP_PER ticks.
  int m_d[2];
  bit m_c[2], m_b[2];
  int m_key, m_n;

  always @(posedge clk or negedge rst) begin : model
    int nd[2];
    bit nc[2], nb[2];
    int nk, nn, dir, lv;
    bit stp;
    if (!rst) begin
      for (int i = 0; i < 2; i++) begin
        m_d[i] <= rst_v[i];
        m_c[i] <= 1'b0;
        m_b[i] <= 1'b0;
      end
      m_key <= 0;
      m_n   <= 0;
    end else begin
      nk = m_key; nn = m_n; stp = 1'b0; dir = 0;
      for (int i = 0; i < 2; i++) begin
        nd[i] = m_d[i]; nc[i] = 1'b0; nb[i] = 1'b0;
      end
      if (load) begin
        lv = int'(load_val);
        for (int i = 0; i < 2; i++)
          nd[i] = (lv < mn_v[i]) ? mn_v[i] : (lv > mx_v[i]) ? mx_v[i] : lv;
        nk = 0; nn = 0;
      end else if (!pause && en) begin
        if (key == 2'b01 || key == 2'b10) begin
          dir = (key == 2'b01) ? 1 : 2;
          if (dir == m_key) begin
            nn  = m_n + 1;
            stp = (REP_DLY > 0) && (nn > REP_DLY) && (((nn - REP_DLY - 1) % REP_PER) == 0);
          end else begin
            nk = dir; nn = 0; stp = 1'b1;
          end
        end else begin
          nk = 0; nn = 0;
        end
        if (stp) begin
          for (int i = 0; i < 2; i++) begin
            if (dir == 1) begin
              if (nd[i] + st_v[i] > mx_v[i]) begin
                if (mode) nd[i] = mx_v[i];
                else begin nd[i] = mn_v[i]; nc[i] = 1'b1; end
              end else nd[i] = nd[i] + st_v[i];
            end else begin
              if (nd[i] < mn_v[i] + st_v[i]) begin
                if (mode) nd[i] = mn_v[i];
                else begin nd[i] = mx_v[i]; nb[i] = 1'b1; end
              end else nd[i] = nd[i] - st_v[i];
            end
          end
        end
      end
      for (int i = 0; i < 2; i++) begin
        m_d[i] <= nd[i];
        m_c[i] <= nc[i];
        m_b[i] <= nb[i];
      end
      m_key <= nk;
      m_n   <= nn;
    end
  end

  task automatic cmp_one(input int i, input logic [7:0] d, input logic c, input logic b,
                         input logic mx, input logic mn);
    logic emx, emn;
    emx = (m_d[i] == mx_v[i]);
    emn = (m_d[i] == mn_v[i]);
    n_cmp++;
    if (d !== 8'(m_d[i]) || c !== m_c[i] || b !== m_b[i] || mx !== emx || mn !== emn) begin
      n_bad++;
      $display("FAIL model_u%0d t=%0t: got d=%0d c=%0b b=%0b max=%0b min=%0b, need d=%0d c=%0b b=%0b max=%0b min=%0b",
               i, $time, d, c, b, mx, mn, m_d[i], m_c[i], m_b[i], emx, emn);
    end
  endtask

  always @(negedge clk) begin
    cmp_one(0, d0, c0, b0, mx0, mn0);
    cmp_one(1, d1, c1, b1, mx1, mn1);
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, need %0d", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  initial begin
    en = 1'b1; pause = 1'b0; load = 1'b0; mode = 1'b0; key = 2'b00; load_val = 8'd0;
    tick(2);
    chk("reset_d0", int'(d0), 2);
    chk("reset_c0b0", int'({c0, b0}), 0);
    chk("reset_at_min0", int'(mn0), 1);
    chk("reset_d1", int'(d1), 0);
    rst = 1'b1;
    tick(1);

    load = 1'b1; load_val = 8'd11; tick(1);
    load = 1'b0;
    chk("load11_at_max", int'(mx0), 1);
    key = 2'b01; tick(1);
    chk("wrap_up_d0", int'(d0), 2);
    chk("wrap_up_c0", int'(c0), 1);
    key = 2'b00; tick(1);
    chk("wrap_up_c0_clear", int'(c0), 0);

    key = 2'b01;
    tick(1); chk("hold_t0", int'(d0), 3);
    tick(4); chk("hold_t4", int'(d0), 3);
    tick(1); chk("hold_t5", int'(d0), 4);
    tick(2); chk("hold_t7", int'(d0), 5);
    tick(2); chk("hold_t9", int'(d0), 6);
    key = 2'b00; tick(1);

    mode = 1'b1;
    load = 1'b1; load_val = 8'd2; tick(1);
    load = 1'b0; key = 2'b10; tick(8);
    chk("sat_dn_d0", int'(d0), 2);
    key = 2'b00; load = 1'b1; load_val = 8'd200; tick(1);
    load = 1'b0;
    chk("clamp200_d0", int'(d0), 11);
    chk("clamp200_d1", int'(d1), 9);

    mode = 1'b0;
    load = 1'b1; load_val = 8'd5; tick(1);
    load = 1'b0; key = 2'b01; tick(1);
    chk("press_5_to_6", int'(d0), 6);
    pause = 1'b1; tick(3);
    chk("pause_hold", int'(d0), 6);
    pause = 1'b0; key = 2'b11; tick(2);
    chk("both_keys", int'(d0), 6);
    key = 2'b00; tick(1);

    load = 1'b1; load_val = 8'd2; tick(1);
    load = 1'b0; key = 2'b01; tick(3);
    chk("pre_pause", int'(d0), 3);
    pause = 1'b1; tick(5);
    pause = 1'b0; tick(2);
    chk("timer_frozen", int'(d0), 3);
    tick(1);
    chk("timer_resumed", int'(d0), 4);
    tick(2);
    chk("in_rpt", int'(d0), 5);
    rst = 1'b0; #1;
    chk("async_rst_d0", int'(d0), 2);
    tick(1);
    rst = 1'b1; tick(1);
    chk("press_after_rst", int'(d0), 3);
    key = 2'b00; tick(1);

    en = 1'b0; key = 2'b01; tick(3);
    chk("en_low_hold", int'(d0), 3);
    en = 1'b1; key = 2'b00; tick(1);

    load = 1'b1; load_val = 8'd8; tick(1);
    load = 1'b0;
    chk("u1_load8", int'(d1), 8);
    key = 2'b01; tick(1);
    chk("u1_wrap_up_d", int'(d1), 0);
    chk("u1_wrap_up_c", int'(c1), 1);
    key = 2'b00; tick(1);
    chk("u1_c_clear", int'(c1), 0);
    load = 1'b1; load_val = 8'd1; tick(1);
    load = 1'b0; key = 2'b10; tick(1);
    chk("u1_wrap_dn_d", int'(d1), 9);
    chk("u1_wrap_dn_b", int'(b1), 1);
    chk("u0_wrap_dn_b", int'(b0), 1);
    key = 2'b00; tick(1);

    mode = 1'b1;
    load = 1'b1; load_val = 8'd8; tick(1);
    load = 1'b0; key = 2'b01; tick(1);
    chk("u1_sat_up_d", int'(d1), 9);
    chk("u1_sat_up_c", int'(c1), 0);
    key = 2'b00; tick(1);

    pause = 1'b1; load = 1'b1; load_val = 8'd5; tick(1);
    load = 1'b0;
    chk("load_in_pause_d0", int'(d0), 5);
    chk("load_in_pause_d1", int'(d1), 5);
    pause = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
